rename_register_file: RTL

Parametrised architectural register file with per-register rename tags for the out-of-order core; successor to the single-commit RF. Holds NREG committed values plus a busy bit and ROB tag per register, serves NRD combinational operand lookups to dispatch, accepts one rename (launch) and up to NCM in-order commits per cycle from the ROB. Broadcasts each commit to the reservation stations and load/store buffer one cycle later.

---
 rtl/rename_register_file.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/rename_register_file.sv
// Architectural register file with per-register rename tags: combinational operand
// lookup with launch/commit bypass, one rename and up to NCM in-order commits per cycle.
module rename_register_file #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int TAG_W = 5,
  parameter int NRD   = 2,
  parameter int NCM   = 2,
  localparam int RIDX_W = $clog2(NREG)
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   rdy_in,
  input  logic                   flush_in,
  input  logic                   launch_valid_in,
  input  logic [RIDX_W-1:0]      launch_rd_in,
  input  logic [TAG_W-1:0]       launch_tag_in,
  input  logic [NCM-1:0]         commit_valid_in,
  input  logic [NCM*RIDX_W-1:0]  commit_rd_in,
  input  logic [NCM*TAG_W-1:0]   commit_tag_in,
  input  logic [NCM*XLEN-1:0]    commit_value_in,
  input  logic [NRD*RIDX_W-1:0]  ask_rd_in,
  output logic [NRD-1:0]         dep_busy_out,
  output logic [NRD*TAG_W-1:0]   dep_tag_out,
  output logic [NRD*XLEN-1:0]    dep_value_out,
  output logic [NCM-1:0]         msg_valid_out,
  output logic [NCM*TAG_W-1:0]   msg_tag_out,
  output logic [NCM*XLEN-1:0]    msg_value_out
);

  logic [XLEN-1:0]      value_q [NREG];
  logic [XLEN-1:0]      value_d [NREG];
  logic [TAG_W-1:0]     tag_q   [NREG];
  logic [TAG_W-1:0]     tag_d   [NREG];
  logic [NREG-1:0]      busy_q, busy_d;
  logic [NCM-1:0]       msg_valid_q, msg_valid_d;
  logic [NCM*TAG_W-1:0] msg_tag_q, msg_tag_d;
  logic [NCM*XLEN-1:0]  msg_value_q, msg_value_d;

  logic [RIDX_W-1:0]    c_rd_s  [NCM];
  logic [TAG_W-1:0]     c_tag_s [NCM];
  logic [XLEN-1:0]      c_val_s [NCM];
  logic [RIDX_W-1:0]    a_rd_s  [NRD];
  logic [NCM-1:0]       c_act_s;
  logic [NCM-1:0]       c_shadow_s;
  logic                 l_act_s;

  // Unpack ports; an active op is one that will really touch state this cycle.
  always_comb begin
    l_act_s = rdy_in & launch_valid_in & ~flush_in & (launch_rd_in != {RIDX_W{1'b0}});
    for (int k = 0; k < NCM; k++) begin
      c_rd_s[k]  = commit_rd_in[k*RIDX_W +: RIDX_W];
      c_tag_s[k] = commit_tag_in[k*TAG_W +: TAG_W];
      c_val_s[k] = commit_value_in[k*XLEN +: XLEN];
      c_act_s[k] = rdy_in & commit_valid_in[k] & (c_rd_s[k] != {RIDX_W{1'b0}});
    end
    // A younger commit to the same rd keeps an older one from clearing busy.
    for (int k = 0; k < NCM; k++) begin
      c_shadow_s[k] = 1'b0;
      for (int j = k + 1; j < NCM; j++) begin
        if (c_act_s[j] && (c_rd_s[j] == c_rd_s[k])) begin
          c_shadow_s[k] = 1'b1;
        end else begin
          c_shadow_s[k] = c_shadow_s[k];
        end
      end
    end
    for (int p = 0; p < NRD; p++) begin
      a_rd_s[p] = ask_rd_in[p*RIDX_W +: RIDX_W];
    end
  end

  // Register state next-value: commits, then launch, then flush override.
  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    busy_d  = busy_q;
    for (int k = 0; k < NCM; k++) begin
      if (c_act_s[k]) begin
        value_d[c_rd_s[k]] = c_val_s[k];
        if ((tag_q[c_rd_s[k]] == c_tag_s[k]) && !c_shadow_s[k] &&
            !(l_act_s && (launch_rd_in == c_rd_s[k]))) begin
          busy_d[c_rd_s[k]] = 1'b0;
        end else begin
          busy_d[c_rd_s[k]] = busy_d[c_rd_s[k]];
        end
      end else begin
        value_d = value_d;
      end
    end
    if (l_act_s) begin
      busy_d[launch_rd_in] = 1'b1;
      tag_d[launch_rd_in]  = launch_tag_in;
    end else begin
      tag_d = tag_d;
    end
    if (rdy_in && flush_in) begin
      busy_d = {NREG{1'b0}};
    end else begin
      busy_d = busy_d;
    end
  end

  // Operand lookup: launch bypass, then youngest matching commit, then stored state.
  always_comb begin
    dep_busy_out  = {NRD{1'b0}};
    dep_tag_out   = {(NRD*TAG_W){1'b0}};
    dep_value_out = {(NRD*XLEN){1'b0}};
    for (int p = 0; p < NRD; p++) begin
      if (a_rd_s[p] == {RIDX_W{1'b0}}) begin
        dep_busy_out[p] = 1'b0;
      end else if (l_act_s && (launch_rd_in == a_rd_s[p])) begin
        dep_busy_out[p]                  = 1'b1;
        dep_tag_out[p*TAG_W +: TAG_W]    = launch_tag_in;
      end else begin
        dep_busy_out[p]                  = busy_q[a_rd_s[p]];
        dep_tag_out[p*TAG_W +: TAG_W]    = tag_q[a_rd_s[p]];
        dep_value_out[p*XLEN +: XLEN]    = value_q[a_rd_s[p]];
        for (int k = 0; k < NCM; k++) begin
          if (c_act_s[k] && (c_rd_s[k] == a_rd_s[p]) && busy_q[a_rd_s[p]] &&
              (tag_q[a_rd_s[p]] == c_tag_s[k])) begin
            dep_busy_out[p]               = 1'b0;
            dep_value_out[p*XLEN +: XLEN] = c_val_s[k];
          end else begin
            dep_busy_out[p] = dep_busy_out[p];
          end
        end
      end
    end
  end

  // Commit broadcast next-value; holds while stalled, silenced by flush.
  always_comb begin
    msg_valid_d = msg_valid_q;
    msg_tag_d   = msg_tag_q;
    msg_value_d = msg_value_q;
    if (rdy_in) begin
      for (int k = 0; k < NCM; k++) begin
        msg_valid_d[k]                = commit_valid_in[k] & ~flush_in;
        msg_tag_d[k*TAG_W +: TAG_W]   = c_tag_s[k];
        msg_value_d[k*XLEN +: XLEN]   = (c_rd_s[k] == {RIDX_W{1'b0}}) ? {XLEN{1'b0}} : c_val_s[k];
      end
    end else begin
      msg_valid_d = msg_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NREG; i++) begin
        value_q[i] <= {XLEN{1'b0}};
        tag_q[i]   <= {TAG_W{1'b0}};
      end
      busy_q      <= {NREG{1'b0}};
      msg_valid_q <= {NCM{1'b0}};
      msg_tag_q   <= {(NCM*TAG_W){1'b0}};
      msg_value_q <= {(NCM*XLEN){1'b0}};
    end else begin
      value_q     <= value_d;
      tag_q       <= tag_d;
      busy_q      <= busy_d;
      msg_valid_q <= msg_valid_d;
      msg_tag_q   <= msg_tag_d;
      msg_value_q <= msg_value_d;
    end
  end

  assign msg_valid_out = msg_valid_q;
  assign msg_tag_out   = msg_tag_q;
  assign msg_value_out = msg_value_q;

endmodule
